// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared phase encoding, default dwell constants and counter
//                width for the intersection scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  localparam int CNT_W = 8;

  localparam int c_T_GREEN_A = 60;
  localparam int c_T_GREEN_B = 30;
  localparam int c_T_YELLOW  = 5;
  localparam int c_T_ALLRED  = 2;
  localparam int c_T_PED     = 10;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    CLR_AB   = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    CLR_BA   = 3'd5
  } phase_t;

  // Successor in the fixed ring A_GREEN -> ... -> CLR_BA -> A_GREEN.
  function automatic phase_t next_phase(input phase_t s);
    case (s)
      A_GREEN:  next_phase = A_YELLOW;
      A_YELLOW: next_phase = CLR_AB;
      CLR_AB:   next_phase = B_GREEN;
      B_GREEN:  next_phase = B_YELLOW;
      B_YELLOW: next_phase = CLR_BA;
      default:  next_phase = A_GREEN;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_timer
//  Description : Down-counter holding the cycles left in the current phase.
//                A load has priority over the per-cycle decrement.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_timer
  import traffic_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = CNT_W'(c_T_ALLRED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] r_cnt;

  // Counter register: reset value, then load or decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= RST_VAL;
    end else if (load) begin
      r_cnt <= load_val;
    end else begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign cnt  = r_cnt;
  assign last = (r_cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/intersection_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : intersection_scheduler
//  Description : Two-approach signal sequencer with side-road demand hold,
//                pedestrian green cut and a remaining-time countdown output.
//  Revision    : 1.0 - initial release
// ============================================================================
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int T_GREEN_A = c_T_GREEN_A,
  parameter int T_GREEN_B = c_T_GREEN_B,
  parameter int T_YELLOW  = c_T_YELLOW,
  parameter int T_ALLRED  = c_T_ALLRED,
  parameter int T_PED     = c_T_PED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ped_req,
  input  logic             car_b,
  output logic             red_a,
  output logic             yellow_a,
  output logic             green_a,
  output logic             red_b,
  output logic             yellow_b,
  output logic             green_b,
  output logic [CNT_W-1:0] clock,
  output logic             ped_walk
);

  localparam logic [CNT_W-1:0] c_GREEN_A = CNT_W'(T_GREEN_A);
  localparam logic [CNT_W-1:0] c_GREEN_B = CNT_W'(T_GREEN_B);
  localparam logic [CNT_W-1:0] c_YELLOW  = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] c_ALLRED  = CNT_W'(T_ALLRED);
  localparam logic [CNT_W-1:0] c_PED     = CNT_W'(T_PED);

  phase_t           r_state;
  phase_t           w_next_state;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_cnt;
  logic             w_last;
  logic             r_dem_b;
  logic             r_ped_pend;
  logic             w_enter_b_green;
  logic             w_enter_a_yellow;

  // Dwell loaded on entry to each phase.
  function automatic logic [CNT_W-1:0] dwell(input phase_t s);
    case (s)
      A_GREEN:            dwell = c_GREEN_A;
      B_GREEN:            dwell = c_GREEN_B;
      A_YELLOW, B_YELLOW: dwell = c_YELLOW;
      default:            dwell = c_ALLRED;
    endcase
  endfunction

  phase_timer #(
    .RST_VAL (c_ALLRED)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .cnt      (w_cnt),
    .last     (w_last)
  );

  // Next phase and timer load: transition beats extension beats cut.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = w_cnt;
    if (w_last) begin
      w_load = 1'b1;
      if (r_state == A_GREEN && !r_dem_b) begin
        w_load_val = c_GREEN_A;
      end else begin
        w_next_state = next_phase(r_state);
        w_load_val   = dwell(w_next_state);
      end
    end else if (r_state == A_GREEN && r_ped_pend && w_cnt > c_PED) begin
      w_load     = 1'b1;
      w_load_val = c_PED;
    end
  end

  assign w_enter_b_green  = (w_next_state == B_GREEN)  && (r_state != B_GREEN);
  assign w_enter_a_yellow = (w_next_state == A_YELLOW) && (r_state != A_YELLOW);

  // Phase state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLR_BA;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Demand and pedestrian flags; a new request wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dem_b    <= 1'b0;
      r_ped_pend <= 1'b0;
    end else begin
      if (car_b || ped_req) begin
        r_dem_b <= 1'b1;
      end else if (w_enter_b_green) begin
        r_dem_b <= 1'b0;
      end
      if (ped_req) begin
        r_ped_pend <= 1'b1;
      end else if (w_enter_a_yellow) begin
        r_ped_pend <= 1'b0;
      end
    end
  end

  // Moore lamp decode: any approach not explicitly lit shows red.
  always_comb begin
    red_a    = 1'b1;
    yellow_a = 1'b0;
    green_a  = 1'b0;
    red_b    = 1'b1;
    yellow_b = 1'b0;
    green_b  = 1'b0;
    case (r_state)
      A_GREEN:  begin red_a = 1'b0; green_a  = 1'b1; end
      A_YELLOW: begin red_a = 1'b0; yellow_a = 1'b1; end
      B_GREEN:  begin red_b = 1'b0; green_b  = 1'b1; end
      B_YELLOW: begin red_b = 1'b0; yellow_b = 1'b1; end
      default:  ;
    endcase
  end

  assign ped_walk = (r_state == B_GREEN);
  assign clock    = w_cnt;

endmodule
`default_nettype wire

// File: tb/tb_intersection_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intersection_scheduler
//  Description : Self-checking bench for intersection_scheduler using a
//                cycle model feeding an expected-value queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_intersection_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ped_req = 1'b0;
  logic       car_b = 1'b0;
  logic       red_a, yellow_a, green_a, red_b, yellow_b, green_b, ped_walk;
  logic [7:0] clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: 0 A_GREEN,1 A_YELLOW,2 CLR_AB,3 B_GREEN,4 B_YELLOW,5 CLR_BA
  int  m_state = 5;
  int  m_cnt   = 2;
  bit  m_dem   = 1'b0;
  bit  m_ped   = 1'b0;
  logic [14:0] sb[$];
  logic [14:0] exp_v;

  intersection_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .ped_req  (ped_req),
    .car_b    (car_b),
    .red_a    (red_a),
    .yellow_a (yellow_a),
    .green_a  (green_a),
    .red_b    (red_b),
    .yellow_b (yellow_b),
    .green_b  (green_b),
    .clock    (clock),
    .ped_walk (ped_walk)
  );

  always #5 clk = ~clk;

  function automatic int m_dwell(input int s);
    case (s)
      0:       return 60;
      3:       return 30;
      1, 4:    return 5;
      default: return 2;
    endcase
  endfunction

  function automatic logic [14:0] m_pack(input int s, input int c);
    logic ra, ya, ga, rb, yb, gb, pw;
    ga = (s == 0); ya = (s == 1); ra = !(ga || ya);
    gb = (s == 3); yb = (s == 4); rb = !(gb || yb);
    pw = (s == 3);
    return {ra, ya, ga, rb, yb, gb, pw, 8'(c)};
  endfunction

  function automatic logic [14:0] obs();
    return {red_a, yellow_a, green_a, red_b, yellow_b, green_b, ped_walk, clock};
  endfunction

  // Drive one cycle of inputs, advance the model and queue its prediction.
  task automatic drive_cycle(input logic r, input logic c, input logic p);
    int ns, nc;
    bit nd, np;
    rst = r; car_b = c; ped_req = p;
    if (r) begin
      ns = 5; nc = 2; nd = 1'b0; np = 1'b0;
    end else begin
      ns = m_state;
      if (m_cnt == 1) begin
        if (m_state == 0 && !m_dem) nc = 60;
        else begin ns = (m_state + 1) % 6; nc = m_dwell(ns); end
      end else if (m_state == 0 && m_ped && m_cnt > 10) nc = 10;
      else nc = m_cnt - 1;
      nd = (c || p) ? 1'b1 : ((ns == 3 && m_state != 3) ? 1'b0 : m_dem);
      np = p ? 1'b1 : ((ns == 1 && m_state != 1) ? 1'b0 : m_ped);
    end
    m_state = ns; m_cnt = nc; m_dem = nd; m_ped = np;
    sb.push_back(m_pack(m_state, m_cnt));
    @(posedge clk);
    #1;
  endtask

  // Lamp safety and one-lamp-per-approach on every cycle after reset.
  always @(negedge clk) begin
    if (!$isunknown({red_a, yellow_a, green_a, red_b, yellow_b, green_b})) begin
      n_cmp++;
      if (((yellow_a | green_a) & (yellow_b | green_b)) === 1'b1 ||
          (red_a + yellow_a + green_a) != 2'd1 || (red_b + yellow_b + green_b) != 2'd1) begin
        n_fail++;
        $display("FAIL lamp_safety t=%0t: got a=%b%b%b b=%b%b%b, required one lamp per approach and not both non-red",
                 $time, red_a, yellow_a, green_a, red_b, yellow_b, green_b);
      end
    end
  end

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL reset: got %h required %h", obs(), exp_v); end
    end
    n_cmp++;
    if ({red_a, yellow_a, green_a, red_b, yellow_b, green_b, ped_walk, clock} !== {7'b1001000, 8'd2}) begin
      n_fail++; $display("FAIL reset_const: got %h required %h", obs(), {7'b1001000, 8'd2});
    end
  endtask

  task automatic test_full_cycle();
    logic [13:0] want;
    for (int k = 1; k <= 106; k++) begin
      drive_cycle(1'b0, 1'b1, 1'b0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL full_cycle k=%0d: got %h required %h", k, obs(), exp_v); end
      want = 14'h0;
      case (k)
        2:   want = {6'b001100, 8'd60};
        62:  want = {6'b010100, 8'd5};
        67:  want = {6'b100100, 8'd2};
        69:  want = {6'b100001, 8'd30};
        99:  want = {6'b100010, 8'd5};
        104: want = {6'b100100, 8'd2};
        106: want = {6'b001100, 8'd60};
        default: ;
      endcase
      if (want != 14'h0) begin
        n_cmp++;
        if ({red_a, yellow_a, green_a, red_b, yellow_b, green_b, clock} !== want) begin
          n_fail++; $display("FAIL full_cycle_phase k=%0d: got %h required %h", k, obs(), want);
        end
      end
    end
  endtask

  task automatic test_no_demand();
    bit gb_seen = 1'b0;
    drive_cycle(1'b1, 1'b0, 1'b0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL no_demand_rst: got %h required %h", obs(), exp_v); end
    for (int k = 1; k <= 200; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL no_demand k=%0d: got %h required %h", k, obs(), exp_v); end
      if (green_b === 1'b1) gb_seen = 1'b1;
      if (k == 62) begin
        n_cmp++;
        if ({green_a, clock} !== {1'b1, 8'd60}) begin
          n_fail++; $display("FAIL extension_reload: got green_a=%b clock=%0d required 1/60", green_a, clock);
        end
      end
    end
    n_cmp++;
    if (gb_seen) begin n_fail++; $display("FAIL no_demand_green_b: got seen=1 required 0"); end
  endtask

  task automatic test_ped_cut();
    int guard = 0;
    int pw = 0;
    while (!(green_a === 1'b1 && clock === 8'd40) && guard < 200) begin
      guard++;
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL ped_cut_wait: got %h required %h", obs(), exp_v); end
    end
    n_cmp++;
    if (guard >= 200) begin n_fail++; $display("FAIL ped_cut_timeout: got no clock=40 required clock=40"); end
    drive_cycle(1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL ped_cut_pulse: got %h required %h", obs(), exp_v); end
    drive_cycle(1'b0, 1'b0, 1'b0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL ped_cut_load: got %h required %h", obs(), exp_v); end
    n_cmp++;
    if ({green_a, clock} !== {1'b1, 8'd10}) begin
      n_fail++; $display("FAIL ped_cut_value: got green_a=%b clock=%0d required 1/10", green_a, clock);
    end
    for (int k = 1; k <= 10; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL ped_cut_count k=%0d: got %h required %h", k, obs(), exp_v); end
    end
    n_cmp++;
    if ({yellow_a, clock} !== {1'b1, 8'd5}) begin
      n_fail++; $display("FAIL ped_cut_yellow: got yellow_a=%b clock=%0d required 1/5", yellow_a, clock);
    end
    for (int k = 1; k <= 43; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL ped_walk_run k=%0d: got %h required %h", k, obs(), exp_v); end
      if (ped_walk === 1'b1) pw++;
    end
    n_cmp++;
    if (pw != 30) begin n_fail++; $display("FAIL ped_walk_len: got %0d required 30", pw); end
  endtask

  task automatic test_ped_late();
    int guard = 0;
    int gb = 0;
    while (!(green_a === 1'b1 && clock === 8'd7) && guard < 200) begin
      guard++;
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL ped_late_wait: got %h required %h", obs(), exp_v); end
    end
    n_cmp++;
    if (guard >= 200) begin n_fail++; $display("FAIL ped_late_timeout: got no clock=7 required clock=7"); end
    drive_cycle(1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL ped_late_pulse: got %h required %h", obs(), exp_v); end
    for (int k = 1; k <= 6; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL ped_late_count k=%0d: got %h required %h", k, obs(), exp_v); end
    end
    n_cmp++;
    if ({yellow_a, clock} !== {1'b1, 8'd5}) begin
      n_fail++; $display("FAIL ped_late_yellow: got yellow_a=%b clock=%0d required 1/5", yellow_a, clock);
    end
    for (int k = 1; k <= 43; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL ped_late_run k=%0d: got %h required %h", k, obs(), exp_v); end
      if (green_b === 1'b1) gb++;
    end
    n_cmp++;
    if (gb != 30) begin n_fail++; $display("FAIL ped_late_served: got green_b cycles %0d required 30", gb); end
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    drive_cycle(1'b0, 1'b1, 1'b0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL b2b_pulse: got %h required %h", obs(), exp_v); end
    while (yellow_a !== 1'b1 && guard < 100) begin
      guard++;
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL b2b_wait: got %h required %h", obs(), exp_v); end
    end
    n_cmp++;
    if (guard >= 100) begin n_fail++; $display("FAIL b2b_timeout: got no yellow_a required yellow_a"); end
    for (int k = 1; k <= 6; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL b2b_clr k=%0d: got %h required %h", k, obs(), exp_v); end
    end
    drive_cycle(1'b0, 1'b1, 1'b0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL b2b_entry: got %h required %h", obs(), exp_v); end
    n_cmp++;
    if ({green_b, clock} !== {1'b1, 8'd30}) begin
      n_fail++; $display("FAIL b2b_green_b: got green_b=%b clock=%0d required 1/30", green_b, clock);
    end
    for (int k = 1; k <= 97; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL b2b_run k=%0d: got %h required %h", k, obs(), exp_v); end
    end
    n_cmp++;
    if ({yellow_a, clock} !== {1'b1, 8'd5}) begin
      n_fail++; $display("FAIL b2b_no_extension: got yellow_a=%b clock=%0d required 1/5", yellow_a, clock);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (!(green_b === 1'b1 && clock === 8'd15) && guard < 100) begin
      guard++;
      drive_cycle(1'b0, 1'b1, 1'b1);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL rst_mid_wait: got %h required %h", obs(), exp_v); end
    end
    n_cmp++;
    if (guard >= 100) begin n_fail++; $display("FAIL rst_mid_timeout: got no clock=15 required clock=15"); end
    drive_cycle(1'b1, 1'b0, 1'b0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL rst_mid: got %h required %h", obs(), exp_v); end
    n_cmp++;
    if (obs() !== {7'b1001000, 8'd2}) begin
      n_fail++; $display("FAIL rst_mid_const: got %h required %h", obs(), {7'b1001000, 8'd2});
    end
    for (int k = 1; k <= 62; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL rst_mid_run k=%0d: got %h required %h", k, obs(), exp_v); end
      if (k == 3 || k == 62) begin
        n_cmp++;
        if ({green_a, clock} !== {1'b1, (k == 3) ? 8'd59 : 8'd60}) begin
          n_fail++; $display("FAIL rst_mid_flags k=%0d: got green_a=%b clock=%0d required 1/%0d",
                             k, green_a, clock, (k == 3) ? 59 : 60);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_no_demand();
    test_ped_cut();
    test_ped_late();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/intersection_scheduler.md
# intersection_scheduler

Two-approach intersection scheduler. It sequences the main road (A) and side road (B) lamp sets through green, yellow and all-red clearance phases, and guarantees that the two approaches are never both non-red. It shortens the main-road green on a pedestrian request and holds main-road green while the side road has no demand. It sits above the per-approach lamp drivers and exports the remaining phase time for the countdown display.

## Interface
Parameters:
- T_GREEN_A, 60: main-road green dwell, in cycles.
- T_GREEN_B, 30: side-road green dwell, in cycles.
- T_YELLOW, 5: yellow dwell, in cycles, for both approaches.
- T_ALLRED, 2: all-red clearance dwell, in cycles.
- T_PED, 10: main-road green remaining after a pedestrian cut. Must satisfy 1 ≤ T_PED < T_GREEN_A.
- All durations are in the range 1..255.

Ports:
- clk, in, 1: the single clock.
- rst, in, 1: reset, synchronous and active-high.
- ped_req, in, 1: single-cycle or level request to cross the main road.
- car_b, in, 1: side-road vehicle sensor, level.
- red_a / yellow_a / green_a, out, 1 each: main-road lamps.
- red_b / yellow_b / green_b, out, 1 each: side-road lamps.
- clock, out, 8: cycles remaining in the current phase, including the current cycle.
- ped_walk, out, 1: pedestrian walk indication; high during B_GREEN only.

## Operation
- States: A_GREEN, A_YELLOW, CLR_AB, B_GREEN, B_YELLOW, CLR_BA.
- Normal sequence: A_GREEN → A_YELLOW → CLR_AB → B_GREEN → B_YELLOW → CLR_BA → A_GREEN.
- Lamps are a Moore decode of the state register:
  - A_GREEN: green_a.
  - A_YELLOW: yellow_a.
  - B_GREEN: green_b.
  - B_YELLOW: yellow_b.
  - In every state, every approach not listed is red. Exactly one lamp per approach is high at all times.
- Phase timer: on entry to a state, clock is loaded with that state's dwell. It decrements by 1 each cycle. When clock==1 the state advances on that edge, so each state lasts exactly its dwell. clock is never 0 after reset.
- Demand flag dem_b:
  - Set on any cycle with car_b==1 or ped_req==1.
  - Cleared on the edge entering B_GREEN.
  - If set and clear coincide, set wins, so the request is served in the next cycle round.
- Pedestrian flag ped_pend:
  - Set on ped_req==1.
  - Cleared on the edge entering A_YELLOW.
  - Set wins over clear.
- Green extension: in A_GREEN with clock==1 and dem_b==0, the controller stays in A_GREEN and reloads clock with T_GREEN_A instead of advancing.
- Pedestrian cut:
  - Condition: in A_GREEN, ped_pend==1 and clock > T_PED.
  - Action: the next clock value is T_PED, not clock-1.
  - If clock ≤ T_PED, the normal decrement applies.
  - At most one cut per A_GREEN, because the cut value is not above T_PED.
- ped_walk is a decode of B_GREEN.

## Timing
- Reset (rst high at a clk edge):
  - State becomes CLR_BA and clock becomes T_ALLRED.
  - dem_b=0, ped_pend=0.
  - Lamp outputs: red_a=1, red_b=1, all others 0. ped_walk=0.
- Reset asserted mid-phase takes effect on that edge and overrides all other updates.
- First A_GREEN begins T_ALLRED cycles after reset deasserts.
- Outputs change only on clk edges. Lamp outputs, clock and ped_walk all reflect the same registered state with zero added latency.
- Input latency: ped_req or car_b sampled at edge n affects flags at edge n. Flags affect transitions from edge n+1 onward.
- Cut priority: a pedestrian cut in the cycle where clock==1 does nothing; the transition wins.
- Round time with continuous demand and no cuts: T_GREEN_A + T_GREEN_B + 2·T_YELLOW + 2·T_ALLRED.

## Structure
- Shared package traffic_pkg:
  - Phase state enum (3-bit encoding).
  - Default duration constants.
  - Counter width constant, CNT_W=8.
- One sub-module, phase_timer:
  - Inputs: load, load_val, with load taking priority over decrement.
  - Outputs: cnt and last (cnt==1).
  - Instantiated once. The FSM computes load_val from the next state, the extension rule or the cut rule.

## Test plan
- Reset release with car_b held high: CLR_BA for 2 cycles, then A_GREEN for 60, A_YELLOW 5, CLR_AB 2, B_GREEN 30, B_YELLOW 5, CLR_BA 2. clock follows 60..1, 5..1, and so on.
- car_b=0 and ped_req=0 throughout: A_GREEN repeats indefinitely with clock reloading to 60. green_b is never asserted.
- ped_req pulse at A_GREEN clock=40: next clock=10, yellow_a 10 cycles later. ped_walk is high for all 30 B_GREEN cycles.
- ped_req pulse at A_GREEN clock=7: no cut, normal countdown. B_GREEN is still served because the pulse set dem_b.
- car_b pulse exactly on the edge entering B_GREEN: dem_b remains 1, and the next A_GREEN advances after 60 cycles with no extension.
- rst asserted for 1 cycle during B_GREEN at clock=15: next cycle both approaches red, clock=2, flags 0. A lamp-safety assertion checks that green or yellow is never high on both approaches in any cycle.
